// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: unsigned A times signed B, one Booth digit per cycle.
// IDLE -> RUN (B_LEN/2 cycles) -> DONE (one cycle, P updated) -> IDLE.
module booth_seq_mul #(
  parameter int A_LEN = 256,
  parameter int B_LEN = 64,
  parameter int P_LEN = 320,
  localparam int NDIG  = B_LEN / 2,
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [A_LEN-1:0] A,
  input  logic [B_LEN-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [P_LEN-1:0] P,
  output logic             neg,
  output logic             zero,
  output logic             one,
  output logic             two,
  output logic [IDX_W-1:0] digit_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [P_LEN-1:0]   a_shift_reg;
  logic [B_LEN-1:0]   b_reg;
  logic [P_LEN-1:0]   acc_reg;
  logic [P_LEN-1:0]   p_reg;
  logic [IDX_W-1:0]   cnt_reg;

  logic [B_LEN:0]     b_ext;
  logic [2:0]         trip [NDIG];
  logic [2:0]         triplet;
  logic               last;
  logic [P_LEN-1:0]   mag;
  logic [P_LEN-1:0]   pp;
  logic [P_LEN-1:0]   acc_sum;

  // b_ext[0] supplies the implicit B[-1] = 0 for digit 0
  assign b_ext = {b_reg, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_trip
      assign trip[gi] = b_ext[2*gi +: 3];
    end
  endgenerate

  assign last = (cnt_reg == IDX_W'(NDIG - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outside RUN the triplet is forced to 000, which decodes to the idle digit (zero=1)
  always_comb begin
    triplet = (state_reg == RUN) ? trip[cnt_reg] : 3'b000;
    zero = 1'b0;
    one  = 1'b0;
    two  = 1'b0;
    neg  = 1'b0;
    case (triplet)
      3'b001, 3'b010: one = 1'b1;
      3'b011:         two = 1'b1;
      3'b100:         begin two = 1'b1; neg = 1'b1; end
      3'b101, 3'b110: begin one = 1'b1; neg = 1'b1; end
      default:        zero = 1'b1;
    endcase
  end

  // a_shift_reg already carries the 2i-bit weight of the current digit
  always_comb begin
    mag     = two ? {a_shift_reg[P_LEN-2:0], 1'b0} : (one ? a_shift_reg : '0);
    pp      = neg ? -mag : mag;
    acc_sum = acc_reg + pp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_shift_reg <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      p_reg       <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_shift_reg <= {{(P_LEN - A_LEN){1'b0}}, A};
            b_reg       <= B;
            acc_reg     <= '0;
            cnt_reg     <= '0;
          end
        end
        RUN: begin
          acc_reg     <= acc_sum;
          a_shift_reg <= {a_shift_reg[P_LEN-3:0], 2'b00};
          cnt_reg     <= last ? '0 : cnt_reg + IDX_W'(1);
          if (last) p_reg <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign P         = p_reg;
  assign digit_idx = cnt_reg;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: cycle-count model plus arithmetic product and digit
// reference, checked every cycle, with directed cases and randomized operands.
module tb_booth_seq_mul;

  localparam int AL = 256;
  localparam int BL = 64;
  localparam int PL = 320;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AL-1:0] A;
  logic [BL-1:0] B;
  logic          busy, done, neg, zero, one, two;
  logic [PL-1:0] P;
  logic [4:0]    digit_idx;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  booth_seq_mul #(.A_LEN(AL), .B_LEN(BL), .P_LEN(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .P(P),
    .neg(neg), .zero(zero), .one(one), .two(two), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed product modulo 2^PL from plain wide arithmetic
  function automatic logic [PL-1:0] mul(input logic [AL-1:0] a, input logic [BL-1:0] b);
    logic [PL-1:0] ae, be;
    ae = {{(PL-AL){1'b0}}, a};
    be = {{(PL-BL){b[BL-1]}}, b};
    return ae * be;
  endfunction

  // Booth digit value d = -2*b[2i+1] + b[2i] + b[2i-1]; returns {neg,zero,one,two}
  function automatic logic [3:0] exp_digit(input logic [BL-1:0] b, input int i);
    int lo, d, m;
    lo = (i == 0) ? 0 : int'(b[2*i-1]);
    d  = -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
    m  = (d < 0) ? -d : d;
    return {d < 0, m == 0, m == 1, m == 2};
  endfunction

  // Model: phase 0 = idle, 1..32 = run cycles, 33 = done cycle
  int            phase = 0;
  logic [AL-1:0] ma;
  logic [BL-1:0] mb;
  logic [PL-1:0] exp_p = '0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      exp_p = '0;
    end else if (phase == 0) begin
      if (start) begin
        phase = 1;
        ma = A;
        mb = B;
      end
    end else if (phase == 32) begin
      phase = 33;
      exp_p = mul(ma, mb);
    end else if (phase == 33) begin
      phase = 0;
    end else begin
      phase++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      bit         run;
      logic [3:0] dig;
      run = (phase >= 1) && (phase <= 32);
      dig = run ? exp_digit(mb, phase - 1) : 4'b0100;
      chk("busy", PL'(busy), PL'(phase != 0));
      chk("done", PL'(done), PL'(phase == 33));
      chk("P", P, exp_p);
      chk("digit_idx", PL'(digit_idx), run ? PL'(phase - 1) : '0);
      chk("digit", PL'({neg, zero, one, two}), PL'(dig));
    end
  end

  logic [3:0] d1, d2;

  task automatic start_op(input logic [AL-1:0] a, input logic [BL-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done from cycle k0 on (cycle 1 = first cycle after the accepting edge)
  task automatic wait_done(input int k0, input bit jiggle, output int dk, output logic [PL-1:0] p);
    dk = -1;
    p  = '0;
    for (int k = k0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) d1 = {neg, zero, one, two};
      if (k == 2) d2 = {neg, zero, one, two};
      if (done) begin
        dk = k;
        p  = P;
        break;
      end
      if (jiggle) begin
        A = {8{$urandom}};
        B = {$urandom, $urandom};
      end
    end
    if (dk < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    int            dk;
    logic [PL-1:0] p;
    logic [AL-1:0] amax;
    logic [PL-1:0] e;
    int            dcyc [$];

    amax  = '1;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", PL'(busy), '0);
    chk("reset_done", PL'(done), '0);
    chk("reset_P", P, '0);
    chk("reset_zero", PL'(zero), PL'(1));
    chk("reset_idx", PL'(digit_idx), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 3 * 5
    start_op(256'd3, 64'd5);
    wait_done(1, 1'b0, dk, p);
    chk("r031_done_cycle", PL'(dk), PL'(33));
    chk("r031_P", p, PL'(15));
    @(negedge clk);
    chk("r031_idle_busy", PL'(busy), '0);

    // 3 * 3: digit0 = -1, digit1 = +1
    start_op(256'd3, 64'd3);
    wait_done(1, 1'b0, dk, p);
    chk("r032_digit0", PL'(d1), PL'(4'b1010));
    chk("r032_digit1", PL'(d2), PL'(4'b0010));
    chk("r032_P", p, PL'(9));

    // extremes
    start_op(amax, '1);
    wait_done(1, 1'b0, dk, p);
    e = ({PL{1'b1}} << 256) + PL'(1);
    chk("r033_min1", p, e);
    start_op(amax, {1'b1, 63'd0});
    wait_done(1, 1'b0, dk, p);
    e = PL'(0) - ({{(PL-AL){1'b0}}, amax} << 63);
    chk("r033_minb", p, e);

    // B = 0; then P held through idle
    start_op({8{$urandom}}, 64'd0);
    wait_done(1, 1'b0, dk, p);
    chk("r034_P", p, '0);
    start_op(256'd11, 64'd13);
    wait_done(1, 1'b0, dk, p);
    repeat (5) @(negedge clk);
    chk("r034_hold", P, PL'(143));

    // start re-pulsed in RUN cycle 5 with new operands is ignored
    start_op(256'd7, -64'sd3);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; A = 256'd100; B = 64'd100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, 1'b0, dk, p);
    chk("r035_ignored", p, PL'(0) - PL'(21));
    chk("r035_done_cycle", PL'(dk), PL'(33));

    // start held high: done pulses 34 cycles apart
    @(posedge clk); #1;
    start = 1'b1; A = 256'd5; B = 64'd6;
    for (int k = 0; k < 75; k++) begin
      @(negedge clk);
      if (done) dcyc.push_back(k);
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("r035_held_count", PL'(dcyc.size() >= 2), PL'(1));
    if (dcyc.size() >= 2) chk("r035_held_period", PL'(dcyc[1] - dcyc[0]), PL'(34));
    repeat (40) @(negedge clk);

    // reset during RUN cycle 10
    start_op(256'd9, 64'd9);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("r036_busy", PL'(busy), '0);
    chk("r036_P", P, '0);
    chk("r036_done", PL'(done), '0);
    start_op(256'd12, -64'sd12);
    wait_done(1, 1'b0, dk, p);
    chk("r036_after", p, PL'(0) - PL'(144));

    // randomized operands, idle gaps and operand changes while busy
    for (int n = 0; n < 25; n++) begin
      logic [AL-1:0] ra;
      logic [BL-1:0] rb;
      ra = {8{$urandom}};
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = {1'b1, 63'd0};
        3:       rb = {1'b0, {63{1'b1}}};
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) ra = amax;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      start_op(ra, rb);
      wait_done(1, ($urandom_range(0, 1) == 1), dk, p);
      chk("rand_done_cycle", PL'(dk), PL'(33));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 Parameters SHALL be: A_LEN, default 256, multiplicand width; B_LEN, default 64, multiplier width (even); P_LEN, default 320, product width (= A_LEN + B_LEN).
REQ-002 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 A  input  A_LEN  multiplicand, unsigned; captured when start is accepted.
REQ-006 B  input  B_LEN  multiplier, two's complement signed; captured when start is accepted.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  single-cycle pulse when P becomes valid.
REQ-009 P  output  P_LEN  signed product A*B (two's complement).
REQ-010 neg, zero, one, two  output  1 each  current radix-4 Booth digit controls.
REQ-011 digit_idx  output  clog2(B_LEN/2)  index of the digit currently driven.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at a clock edge SHALL go to RUN, latch A and B, clear the accumulator and set digit_idx=0.
REQ-014 RUN SHALL last exactly B_LEN/2 cycles (32 at default), processing digit digit_idx per cycle and incrementing digit_idx by 1 each cycle.
REQ-015 After digit B_LEN/2-1 is processed, the FSM SHALL go to DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-016 Digit i SHALL be formed from the triplet {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
REQ-017 Triplet encoding: 000/111 -> zero; 001/010 -> +1 (one); 011 -> +2 (two); 100 -> -2 (two, neg); 101/110 -> -1 (one, neg).
REQ-018 Exactly one of zero/one/two SHALL be high in every cycle.
REQ-019 neg SHALL be high only for negative digits; neg=0 whenever zero=1.
REQ-020 Partial product i SHALL be the P_LEN-bit value {0-extended A, times 1 or 2, 0 for zero}, two's-complemented when neg=1.
REQ-021 The accumulator SHALL add partial product i shifted left by 2i bits, modulo 2^P_LEN.
REQ-022 Final P SHALL equal A*B exactly as a P_LEN-bit two's-complement value; no overflow is possible at the default widths.
REQ-023 Latency: start accepted at edge of cycle 0 -> busy=1 in cycles 1..32 (RUN) and 33 (DONE); done=1 and P valid in cycle 33; IDLE in cycle 34.
REQ-024 P SHALL update only on entry to DONE and SHALL hold its value until the next DONE or reset.
REQ-025 start SHALL be ignored in RUN and DONE, so A/B changes during busy have no effect.
REQ-026 If start is held high continuously, starts SHALL be accepted every 34 cycles.
REQ-027 Outside RUN, the digit outputs SHALL be zero=1, neg=one=two=0 and digit_idx=0.

Reset
REQ-028 rst=1 at an edge SHALL force: IDLE, busy=0, done=0, P=0, digit_idx=0, zero=1, neg=one=two=0, accumulator cleared.
REQ-029 rst SHALL take priority over start and over any in-progress operation, including mid-RUN and during DONE.
REQ-030 After rst, a start SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-031 A=3, B=5, start pulse -> done=1 only in cycle 33, P=15, busy=0 in cycle 34.
REQ-032 A=3, B=3 -> digit0: one=1, neg=1; digit1: one=1, neg=0; digits 2..31: zero=1; P=9.
REQ-033 A=2^256-1, B=-1 -> P=2^320-2^256+1; A=2^256-1, B=-2^63 -> P=2^320-(2^256-1)*2^63.
REQ-034 B=0, any A -> zero=1 for all 32 RUN cycles, P=0; P from a previous result is held through the following IDLE.
REQ-035 start pulsed again in RUN cycle 5 with new A/B -> ignored, result of the original operands; start held high -> acceptances at cycles 0 and 34.
REQ-036 rst asserted in RUN cycle 10 -> IDLE next cycle, P=0, no done pulse; a subsequent start completes normally.
